// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480 VGA raster timing generator with per-frame sprite-position sample
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   SW[7:0]      raw sprite position ([3:0] column, [7:4] row)
//   pix_en       one-cycle pixel strobe, once per CLK_DIV clocks
//   hc[9:0]      horizontal count, 0..H_TOTAL-1
//   vc[9:0]      vertical count, 0..V_TOTAL-1
//   hsync        active-low horizontal sync (low while hc < H_SYNC)
//   vsync        active-low vertical sync (low while vc < V_SYNC)
//   vidon        high inside the active window HBP..HFP-1 x VBP..VFP-1
//   frame_start  one-clock pulse on the edge where hc/vc wrap to 0/0
//   sw_pos[7:0]  sprite position handed to the renderer
//
// Optional feature macro: VGA_SW_LATCH_EN
//   defined   - sw_pos is a register loaded from SW on the frame_start edge
//   undefined - sw_pos follows SW combinationally

module vga_sync_gen #(
    parameter int CLK_DIV = 2,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 521,
    parameter int H_SYNC  = 96,
    parameter int V_SYNC  = 2,
    parameter int HBP     = 144,
    parameter int HFP     = 784,
    parameter int VBP     = 31,
    parameter int VFP     = 511
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] SW,
    output logic       pix_en,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       hsync,
    output logic       vsync,
    output logic       vidon,
    output logic       frame_start,
    output logic [7:0] sw_pos
);

    // CLK_DIV is at most 8, so a 3-bit divider always suffices.
    localparam logic [2:0] DIV_MAX  = 3'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0] H_BP     = 10'(HBP);
    localparam logic [9:0] H_FP     = 10'(HFP);
    localparam logic [9:0] V_BP     = 10'(VBP);
    localparam logic [9:0] V_FP     = 10'(VFP);

    logic [2:0] div;
    logic [9:0] hc_next;
    logic [9:0] vc_next;
    logic       frame_wrap;

    // Next-state counters; decoded outputs are registered from these so that
    // sync/video flags always line up with the hc/vc being presented.
    always_comb begin
        hc_next    = hc;
        vc_next    = vc;
        frame_wrap = 1'b0;
        if (pix_en) begin
            if (hc == H_MAX) begin
                hc_next = '0;
                if (vc == V_MAX) begin
                    vc_next    = '0;
                    frame_wrap = 1'b1;
                end else begin
                    vc_next = vc + 10'd1;
                end
            end else begin
                hc_next = hc + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            pix_en      <= 1'b0;
            hc          <= '0;
            vc          <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            vidon       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= (div == DIV_MAX) ? 3'd0 : div + 3'd1;
            pix_en      <= (div == DIV_MAX);
            hc          <= hc_next;
            vc          <= vc_next;
            hsync       <= (hc_next >= H_SYNC_W);
            vsync       <= (vc_next >= V_SYNC_W);
            vidon       <= (hc_next >= H_BP) && (hc_next < H_FP) &&
                           (vc_next >= V_BP) && (vc_next < V_FP);
            frame_start <= frame_wrap;
        end
    end

`ifdef VGA_SW_LATCH_EN
    // Loaded on the same edge that raises frame_start, so the renderer sees
    // one position for the entire frame that follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_pos <= '0;
        end else if (frame_wrap) begin
            sw_pos <= SW;
        end
    end
`else
    assign sw_pos = SW;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - table-driven self-checking bench for vga_sync_gen (reduced raster)

module tb_vga_sync_gen;

    // Reduced raster so a full frame is 20*12*2 = 480 clocks.
    localparam int CLK_DIV = 2;
    localparam int H_TOTAL = 20;
    localparam int V_TOTAL = 12;
    localparam int H_SYNC  = 3;
    localparam int V_SYNC  = 2;
    localparam int HBP     = 5;
    localparam int HFP     = 17;
    localparam int VBP     = 3;
    localparam int VFP     = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] SW;
    logic       pix_en;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       hsync;
    logic       vsync;
    logic       vidon;
    logic       frame_start;
    logic [7:0] sw_pos;

    vga_sync_gen #(
        .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
        .H_SYNC(H_SYNC), .V_SYNC(V_SYNC), .HBP(HBP), .HFP(HFP),
        .VBP(VBP), .VFP(VFP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .SW(SW),
        .pix_en(pix_en),
        .hc(hc),
        .vc(vc),
        .hsync(hsync),
        .vsync(vsync),
        .vidon(vidon),
        .frame_start(frame_start),
        .sw_pos(sw_pos)
    );

    always #5 clk = ~clk;

    // Non-reset edges since reset release.
    int edge_cnt;
    always @(posedge clk) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    typedef struct {
        int         n;
        logic [7:0] sw;
        logic [9:0] hc;
        logic [9:0] vc;
        logic       hs;
        logic       vs;
        logic       vid;
        logic       pix;
        logic       fs;
        logic [7:0] sw_lat;
    } vec_t;

    vec_t tbl[20];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int cnt, vs_low, hs_low, vid_cnt, viol, pc;
    logic [7:0] exp_sw;

    task automatic sweep_sample();
        if (!vsync) vs_low++;
        if (!hsync) hs_low++;
        if (vidon) begin
            vid_cnt++;
            if (hc < 10'(HBP) || hc >= 10'(HFP) || vc < 10'(VBP) || vc >= 10'(VFP)) viol++;
        end
        if (vsync != (vc >= 10'(V_SYNC))) viol++;
    endtask

    initial begin
        // Edge n: pixel p = (n-1)/2 advances on odd n >= 3; hc = p%20, vc = p/20.
        //            n    sw     hc  vc  hs  vs  vid pix fs  sw_lat
        tbl[0]  = '{  0, 8'hA5,  0,  0, 0,  0,  0,  0,  0, 8'h00};
        tbl[1]  = '{  1, 8'hA5,  0,  0, 0,  0,  0,  0,  0, 8'h00};
        tbl[2]  = '{  2, 8'hA5,  0,  0, 0,  0,  0,  1,  0, 8'h00};
        tbl[3]  = '{  3, 8'hA5,  1,  0, 0,  0,  0,  0,  0, 8'h00};
        tbl[4]  = '{  7, 8'hA5,  3,  0, 1,  0,  0,  0,  0, 8'h00};
        tbl[5]  = '{ 51, 8'hA5,  5,  1, 1,  0,  0,  0,  0, 8'h00};
        tbl[6]  = '{ 81, 8'hA5,  0,  2, 0,  1,  0,  0,  0, 8'h00};
        tbl[7]  = '{ 91, 8'hA5,  5,  2, 1,  1,  0,  0,  0, 8'h00};
        tbl[8]  = '{129, 8'hA5,  4,  3, 1,  1,  0,  0,  0, 8'h00};
        tbl[9]  = '{131, 8'hA5,  5,  3, 1,  1,  1,  0,  0, 8'h00};
        tbl[10] = '{132, 8'hA5,  5,  3, 1,  1,  1,  1,  0, 8'h00};
        tbl[11] = '{153, 8'hA5, 16,  3, 1,  1,  1,  0,  0, 8'h00};
        tbl[12] = '{155, 8'hA5, 17,  3, 1,  1,  0,  0,  0, 8'h00};
        tbl[13] = '{161, 8'hA5,  0,  4, 0,  1,  0,  0,  0, 8'h00};
        tbl[14] = '{393, 8'h3C, 16,  9, 1,  1,  1,  0,  0, 8'h00};
        tbl[15] = '{411, 8'h3C,  5, 10, 1,  1,  0,  0,  0, 8'h00};
        tbl[16] = '{479, 8'h3C, 19, 11, 1,  1,  0,  0,  0, 8'h00};
        tbl[17] = '{480, 8'h3C, 19, 11, 1,  1,  0,  1,  0, 8'h00};
        tbl[18] = '{481, 8'h3C,  0,  0, 0,  0,  0,  0,  1, 8'h3C};
        tbl[19] = '{482, 8'h3C,  0,  0, 0,  0,  0,  1,  0, 8'h3C};

        rst = 1'b1;
        SW  = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            SW = tbl[i].sw;
            while (edge_cnt < tbl[i].n) begin
                @(posedge clk);
                #1;
            end
`ifdef VGA_SW_LATCH_EN
            exp_sw = tbl[i].sw_lat;
`else
            exp_sw = tbl[i].sw;
`endif
            chk($sformatf("v%0d.hc", i),     int'(hc),          int'(tbl[i].hc));
            chk($sformatf("v%0d.vc", i),     int'(vc),          int'(tbl[i].vc));
            chk($sformatf("v%0d.hsync", i),  int'(hsync),       int'(tbl[i].hs));
            chk($sformatf("v%0d.vsync", i),  int'(vsync),       int'(tbl[i].vs));
            chk($sformatf("v%0d.vidon", i),  int'(vidon),       int'(tbl[i].vid));
            chk($sformatf("v%0d.pix_en", i), int'(pix_en),      int'(tbl[i].pix));
            chk($sformatf("v%0d.fstart", i), int'(frame_start), int'(tbl[i].fs));
            chk($sformatf("v%0d.sw_pos", i), int'(sw_pos),      int'(exp_sw));
        end

        // Sweep one whole frame (edges 482..961) up to the next frame_start.
        cnt = 0; vs_low = 0; hs_low = 0; vid_cnt = 0; viol = 0;
        sweep_sample();
        while (cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
            sweep_sample();
            if (frame_start) break;
        end
        chk("frame_seen", int'(frame_start), 1);
        chk("frame_period", cnt + 1, H_TOTAL * V_TOTAL * CLK_DIV);
        chk("vsync_low_clks", vs_low, V_SYNC * H_TOTAL * CLK_DIV);
        chk("hsync_low_clks", hs_low, H_SYNC * CLK_DIV * V_TOTAL);
        chk("vidon_clks", vid_cnt, (HFP - HBP) * (VFP - VBP) * CLK_DIV);
        chk("window_violations", viol, 0);

        // Mid-frame reset pulse of one clock.
        repeat (257) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef VGA_SW_LATCH_EN
        exp_sw = 8'h00;
`else
        exp_sw = SW;
`endif
        chk("mrst.hc", int'(hc), 0);
        chk("mrst.vc", int'(vc), 0);
        chk("mrst.hsync", int'(hsync), 0);
        chk("mrst.vsync", int'(vsync), 0);
        chk("mrst.vidon", int'(vidon), 0);
        chk("mrst.pix_en", int'(pix_en), 0);
        chk("mrst.fstart", int'(frame_start), 0);
        chk("mrst.sw_pos", int'(sw_pos), int'(exp_sw));

        pc = 0;
        for (int k = 0; k < 30 && pc < 2; k++) begin
            @(posedge clk);
            #1;
            if (pix_en) begin
                pc++;
                if (pc == 1) chk("mrst.hc_at_pix1", int'(hc), 0);
                if (pc == 2) chk("mrst.hc_at_pix2", int'(hc), 1);
            end
        end
        chk("mrst.pix_pulses", pc, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480 VGA raster timing for the display path: horizontal/vertical counters, active-low sync pulses and the video-enable window. Its `hc`, `vc` and `vidon` outputs drive the sprite/text renderer. Those counters use a horizontal back-porch origin of 144 and a vertical origin of 31. The block also samples the sprite-position switches once per frame so the renderer sees a stable position for a whole frame.

## Interface
- `CLK_DIV`, 2: system clocks per pixel; 50 MHz `clk` gives a 25 MHz pixel rate; legal range 1–8.
- `H_TOTAL`, 800: pixels per line.
- `V_TOTAL`, 521: lines per frame.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `HBP`, 144: first active hc (sync + back porch).
- `HFP`, 784: first inactive hc after the active region.
- `VBP`, 31: first active vc.
- `VFP`, 511: first inactive vc after the active region.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `SW`  in  8  raw sprite position: [3:0] column, [7:4] row.
- `pix_en`  out  1  one-cycle pixel strobe, asserted once per `CLK_DIV` clocks.
- `hc`  out  10  horizontal count, 0..H_TOTAL-1.
- `vc`  out  10  vertical count, 0..V_TOTAL-1.
- `hsync`  out  1  active low; 0 while hc < H_SYNC.
- `vsync`  out  1  active low; 0 while vc < V_SYNC.
- `vidon`  out  1  high iff HBP ≤ hc < HFP and VBP ≤ vc < VFP.
- `frame_start`  out  1  one-cycle pulse when hc=0, vc=0 is first presented after a wrap.
- `sw_pos`  out  8  position value handed to the renderer.

## Operation
- Pixel divider:
  - `div` counts 0..CLK_DIV-1.
  - `pix_en` is registered and is 1 in the cycle after `div` reaches CLK_DIV-1.
  - With CLK_DIV=1, `pix_en` is 1 on every cycle after reset.
- Counters advance only on a clock edge where `pix_en`=1:
  - hc: hc+1, wrapping H_TOTAL-1 → 0.
  - vc: increments only when hc wraps, and itself wraps V_TOTAL-1 → 0.
- `hsync`, `vsync` and `vidon` are registered from the next-state counter values. They therefore always describe the hc/vc currently presented, with no skew.
- Boundaries:
  - hc=HBP-1 → vidon 0.
  - hc=HBP → vidon 1.
  - hc=HFP-1 → vidon 1.
  - hc=HFP → vidon 0.
  - The vertical window follows the same rule using VBP and VFP.
- `frame_start` asserts on the edge where hc goes 799→0 and vc goes 520→0, and lasts exactly one clock. It never asserts on reset exit.
- Reset, with `rst` sampled high on any edge, including mid-line or mid-frame:
  - div=0, pix_en=0, hc=0, vc=0.
  - hsync=0 and vsync=0: the count origin lies inside both sync pulses.
  - vidon=0, frame_start=0.
  - sw_pos=0 when VGA_SW_LATCH_EN is defined.
  - Counting resumes from 0 on the first cycle after `rst` falls.
- Width rules:
  - Comparisons are unsigned, at 10 bits.
  - The parameters must satisfy H_SYNC < HBP < HFP ≤ H_TOTAL ≤ 1024, and the vertical analogue.

## Timing
- First `pix_en` occurs CLK_DIV clocks after `rst` deasserts. With CLK_DIV=2 this is cycle 2, counting the first non-reset cycle as 1.
- Line period = H_TOTAL·CLK_DIV clocks = 1600.
- Frame period = H_TOTAL·V_TOTAL·CLK_DIV clocks = 833,600.
- hsync low time = H_SYNC·CLK_DIV = 192 clocks.
- vsync low time = V_SYNC·H_TOTAL·CLK_DIV = 3200 clocks.
- hc, vc, hsync, vsync and vidon all change on the same edge and are held constant between `pix_en` edges.
- `sw_pos` update is coincident with the `frame_start` edge, when latching is enabled.

## Configuration
- `VGA_SW_LATCH_EN` defined:
  - `sw_pos` is a register loaded from `SW` on the edge where `frame_start` asserts, and is 0 from reset.
  - `SW` changes mid-frame have no effect until the next frame start.
  - If `SW` changes on the same edge as the wrap, the value sampled on that edge is used.
- Undefined:
  - `sw_pos` = `SW` combinationally; no register is inferred.
  - `frame_start` remains present.

## Test plan
- Reset check: hold `rst` 3 clocks with `SW`=8'hA5 → hc=0, vc=0, hsync=0, vsync=0, vidon=0, pix_en=0, frame_start=0, sw_pos=0 (latch on).
- Horizontal timing at CLK_DIV=2:
  - hsync rises when hc becomes 96, i.e. 192 clocks after the start of the line.
  - vidon is 0 at hc=143 and 1 at hc=144 (vc=31).
  - vidon is 1 at hc=783 and 0 at hc=784.
- Wraps:
  - hc 799→0 increments vc.
  - At vc=520, hc=799, the next `pix_en` gives hc=0, vc=0 and frame_start=1 for exactly 1 clock.
  - The next frame_start comes 833,600 clocks later.
- Vertical timing: vsync is low for vc 0–1 only (3200 clocks); vidon never asserts for vc<31 or vc≥511.
- Switch latch (VGA_SW_LATCH_EN):
  - Change `SW` to 8'h3C at vc=200 → sw_pos keeps its old value until frame_start, then becomes 8'h3C.
  - Without the macro, sw_pos follows `SW` in the same cycle.
- Mid-operation reset: assert `rst` at hc=400, vc=250 for 1 clock → all outputs return to reset values and hc=1 appears on the 2nd `pix_en` after release.
